// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with a valid/ready handshake and a flushable pipeline slot.
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_md;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [XLEN-1:0]  r_result;

  logic            w_accept;
  logic            w_last;
  logic            w_in_div;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_accept = in_valid & (r_state == S_IDLE) & ~flush;
  assign w_last   = (r_cnt == CW'(XLEN - 1));

  // Operand decode: signedness, magnitudes and the divide cases that skip iteration
  assign w_in_div = in_op[2];
  assign w_a_sgn  = (in_op == 3'b001) | (in_op == 3'b010) | (in_op == 3'b100) | (in_op == 3'b110);
  assign w_b_sgn  = (in_op == 3'b001) | (in_op == 3'b100) | (in_op == 3'b110);
  assign w_a_neg  = w_a_sgn & in_a[XLEN-1];
  assign w_b_neg  = w_b_sgn & in_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -in_a : in_a;
  assign w_b_mag  = w_b_neg ? -in_b : in_b;
  assign w_b_zero = (in_b == '0);
  assign w_ovf    = ((in_op == 3'b100) | (in_op == 3'b110)) &
                    (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == '1);
  assign w_special = w_in_div & (w_b_zero | w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = in_op[1] ? in_a : '1;
    end else begin
      w_special_res = in_op[1] ? '0 : in_a;
    end
  end

  logic [XLEN:0]     w_msum;
  logic [XLEN:0]     w_rsh;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  // Multiply: r_hi:r_lo shifts right, r_lo[0] selects the add of the multiplicand.
  // Divide: r_lo shifts left into the partial remainder r_hi, quotient bits enter r_lo[0].
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_md} : '0);
  assign w_rsh  = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_rsh - {1'b0, r_md};
  assign w_qbit = ~w_diff[XLEN];

  always_comb begin
    w_hi_nxt = w_msum[XLEN:1];
    w_lo_nxt = {w_msum[0], r_lo[XLEN-1:1]};
    if (r_op[2]) begin
      w_hi_nxt = w_qbit ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_qbit};
    end
  end

  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -w_lo_nxt : w_lo_nxt;
  assign w_rem    = r_neg_r ? -w_hi_nxt : w_hi_nxt;

  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:                  w_final = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011:  w_final = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:          w_final = w_quo;
      default:                 w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_tag    <= '0;
      r_md     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= in_op;
      r_tag   <= in_tag;
      r_md    <= w_in_div ? w_b_mag : w_a_mag;
      r_lo    <= w_in_div ? w_a_mag : w_b_mag;
      r_hi    <= '0;
      r_cnt   <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if ((r_state == S_CALC) && !flush) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= w_final;
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_result = r_result;
  assign out_tag    = r_tag;

endmodule
